playback_ctrl: RTL

- Control stage directly upstream of the note datapath.
- Turns pushbutton levels into the datapath's one-cycle `ld_note` store strobes and `clear` strobes.
- Counts how many notes have been stored.
- During playback, steps `note_counter` through the stored slots and holds `ld_play` high for a fixed note duration, with a silent gap between notes.

---
 rtl/playback_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/playback_ctrl.sv
// -----------------------------------------------------------------------------
// playback_ctrl
//
// Purpose:
//   This is the control stage that sits in front of the note datapath.
//   - Three pushbutton levels are synchronised and turned into one-shot events.
//   - Those events become one-cycle store strobes (ld_note) and clear strobes.
//   - The block counts how many notes are stored.
//   - During playback it walks note_counter through the stored slots. Each note
//     is held on ld_play for NOTE_TICKS cycles, followed by GAP_TICKS silent
//     cycles.
//
// Optional feature (macro LOOP_PLAY_EN):
//   - Defined: playback restarts at slot 1 after the last note's gap and never
//     pulses done.
//   - Undefined (default): playback runs once and finishes through DONE.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   key_store     store button level (asynchronous)
//   key_play      play/stop button level (asynchronous)
//   key_clear     clear button level (asynchronous)
//   ld_note       one-cycle store strobe to the datapath
//   ld_play       high while a note is sounding
//   note_counter  memory slot being played
//   clear         one-cycle clear strobe
//   mute          high whenever no note should sound
//   playing       high from play start until DONE
//   stored_count  number of stored notes (0..16)
//   done          one-cycle pulse at the end of playback
// -----------------------------------------------------------------------------
module playback_ctrl #(
    parameter int NOTE_TICKS = 12500000,
    parameter int GAP_TICKS  = 1250000,
    parameter int CNT_W      = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_store,
    input  logic       key_play,
    input  logic       key_clear,
    output logic       ld_note,
    output logic       ld_play,
    output logic [3:0] note_counter,
    output logic       clear,
    output logic       mute,
    output logic       playing,
    output logic [4:0] stored_count,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_CLEAR,
        S_PLAY_NOTE,
        S_PLAY_GAP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    // Key bit order everywhere: [2]=clear, [1]=play, [0]=store.
    logic [2:0] keys_d;
    logic [2:0] sync1_q, sync2_q, sync3_q;
    logic [2:0] ev;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       nc_q, nc_d;
    logic [4:0]       count_q, count_d;

    // Where playback goes when a gap ends (or when a note ends and there is no gap).
    state_t     exit_state;
    logic [3:0] exit_nc;

    logic ld_note_q, ld_play_q, clear_q, mute_q, playing_q, done_q;
    logic ld_note_d, ld_play_d, clear_d, mute_d, playing_d, done_d;

    assign keys_d = {key_clear, key_play, key_store};

    // sync3 holds the previous synchronised level, so a key that is held down
    // produces exactly one event.
    assign ev = sync2_q & ~sync3_q;

    always_comb begin
        exit_state = S_PLAY_NOTE;
        exit_nc    = nc_q + 4'd1;
        // Slots are played 1..15 then 0, so note_counter equals the number of
        // notes played so far, modulo 16. A full memory (16 notes) ends on slot 0.
        if (nc_q == count_q[3:0]) begin
`ifdef LOOP_PLAY_EN
            exit_state = S_PLAY_NOTE;
            exit_nc    = 4'd1;
`else
            exit_state = S_DONE;
            exit_nc    = nc_q;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nc_d    = nc_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (ev[2]) begin
                    state_d = S_CLEAR;
                    count_d = 5'd0;
                    nc_d    = 4'd0;
                end else if (ev[1] && (count_q != 5'd0)) begin
                    state_d = S_PLAY_NOTE;
                    nc_d    = 4'd1;
                    cnt_d   = '0;
                end else if (ev[0] && (count_q < 5'd16)) begin
                    // Count moves on the same edge as the strobe, so the
                    // datapath and stored_count never disagree.
                    state_d = S_STORE;
                    count_d = count_q + 5'd1;
                end
            end
            S_STORE, S_CLEAR, S_DONE: begin
                state_d = S_IDLE;
            end
            S_PLAY_NOTE: begin
                if (ev[1]) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == NOTE_LAST) begin
                    cnt_d = '0;
                    if (GAP_TICKS == 0) begin
                        state_d = exit_state;
                        nc_d    = exit_nc;
                    end else begin
                        state_d = S_PLAY_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PLAY_GAP: begin
                if (ev[1]) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = exit_state;
                    nc_d    = exit_nc;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state, which keeps them registered
        // and aligned with the state register.
        ld_note_d = (state_d == S_STORE);
        clear_d   = (state_d == S_CLEAR);
        ld_play_d = (state_d == S_PLAY_NOTE);
        mute_d    = (state_d != S_PLAY_NOTE);
        playing_d = (state_d == S_PLAY_NOTE) || (state_d == S_PLAY_GAP);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            nc_q      <= '0;
            count_q   <= '0;
            ld_note_q <= 1'b0;
            ld_play_q <= 1'b0;
            clear_q   <= 1'b0;
            mute_q    <= 1'b1;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sync1_q   <= keys_d;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nc_q      <= nc_d;
            count_q   <= count_d;
            ld_note_q <= ld_note_d;
            ld_play_q <= ld_play_d;
            clear_q   <= clear_d;
            mute_q    <= mute_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    assign ld_note      = ld_note_q;
    assign ld_play      = ld_play_q;
    assign note_counter = nc_q;
    assign clear        = clear_q;
    assign mute         = mute_q;
    assign playing      = playing_q;
    assign stored_count = count_q;
    assign done         = done_q;

endmodule
